// File: rtl/fftframe_capture.sv
// fftframe_capture: per-bin power of the positive-frequency half of an FFT frame into a ping-pong buffer.
// Define FFTCAPTURE_PEAK_EN to track the peak bin (DC excluded) of each handed-over frame.
module fftframe_capture #(
  parameter int LGWIDTH = 10,
  parameter int IWIDTH  = 16,
  parameter int OWIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_sync,
  input  logic [2*IWIDTH-1:0]  i_result,
  input  logic [LGWIDTH-2:0]   i_rd_addr,
  output logic [OWIDTH-1:0]    o_rd_data,
  input  logic                 i_rd_done,
  output logic                 o_frame_ready,
  output logic [15:0]          o_dropped,
  output logic [LGWIDTH-2:0]   o_peak_bin,
  output logic [OWIDTH-1:0]    o_peak_val
);
  localparam int N2 = 1 << (LGWIDTH - 1);
  localparam int PW = 2 * IWIDTH;
  typedef enum logic [1:0] {IDLE, CAPTURE, SKIP} state_t;
  state_t state_q, state_d;
  logic [LGWIDTH-1:0] bin_q, bin_d, cur;
  logic take, swap;
  logic v1_q, v1_d, l1_q, l1_d, v2_q, v2_d, l2_q, l2_d, c3_q, c3_d;
  logic [LGWIDTH-2:0] a1_q, a1_d, a2_q, a2_d;
  logic signed [IWIDTH-1:0] re_q, re_d, im_q, im_d;
  logic [PW-1:0] sqr_q, sqr_d, sqi_q, sqi_d, pwr;
  logic [OWIDTH-1:0] wdata;
  logic wbank_q, wbank_d, ready_q, ready_d;
  logic [15:0] drop_q, drop_d;
  logic [OWIDTH-1:0] mem [2*N2];
  logic unused_lsb;
  always_comb begin
    cur = i_sync ? '0 : bin_q;
    bin_d = i_ce ? cur + LGWIDTH'(1) : bin_q;
    take = i_ce & (i_sync | (state_q != IDLE));
    state_d = take ? (bin_d[LGWIDTH-1] ? SKIP : CAPTURE) : state_q;
    v1_d = take & ~cur[LGWIDTH-1];
    l1_d = &cur[LGWIDTH-2:0];
    a1_d = cur[LGWIDTH-2:0];
    re_d = i_result[PW-1:IWIDTH];
    im_d = i_result[IWIDTH-1:0];
    v2_d = v1_q;
    l2_d = l1_q;
    a2_d = a1_q;
    sqr_d = PW'(re_q) * PW'(re_q);
    sqi_d = PW'(im_q) * PW'(im_q);
    pwr = sqr_q + sqi_q;
    wdata = pwr[PW-1 -: OWIDTH];
    c3_d = v2_q & l2_q;
    // a release in the completion cycle frees the read bank first, so the new frame still swaps in
    swap = c3_q & (~ready_q | i_rd_done);
    wbank_d = wbank_q ^ swap;
    ready_d = swap | (ready_q & ~i_rd_done);
    drop_d = (c3_q & ~swap & ~&drop_q) ? drop_q + 16'd1 : drop_q;
  end
  assign unused_lsb = ^pwr[PW-OWIDTH-1:0];
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      bin_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      c3_q <= 1'b0;
      wbank_q <= 1'b0;
      ready_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      c3_q <= c3_d;
      wbank_q <= wbank_d;
      ready_q <= ready_d;
      drop_q <= drop_d;
    end
    l1_q <= l1_d;
    l2_q <= l2_d;
    a1_q <= a1_d;
    a2_q <= a2_d;
    re_q <= re_d;
    im_q <= im_d;
    sqr_q <= sqr_d;
    sqi_q <= sqi_d;
  end
  // writes follow the post-swap bank so a frame starting on the swap edge lands in the new bank
  always_ff @(posedge i_clk) begin
    if (v2_q) mem[{wbank_d, a2_q}] <= wdata;
    o_rd_data <= mem[{~wbank_q, i_rd_addr}];
  end
  assign o_frame_ready = ready_q;
  assign o_dropped = drop_q;
`ifdef FFTCAPTURE_PEAK_EN
  logic [LGWIDTH-2:0] mbin_q, mbin_d, pbin_q, pbin_d;
  logic [OWIDTH-1:0] mval_q, mval_d, pval_q, pval_d;
  logic upd;
  always_comb begin
    upd = v2_q & ((a2_q == (LGWIDTH-1)'(1)) | ((a2_q != '0) & (wdata > mval_q)));
    mbin_d = upd ? a2_q : mbin_q;
    mval_d = upd ? wdata : mval_q;
    pbin_d = swap ? mbin_q : pbin_q;
    pval_d = swap ? mval_q : pval_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mbin_q <= '0;
      mval_q <= '0;
      pbin_q <= '0;
      pval_q <= '0;
    end else begin
      mbin_q <= mbin_d;
      mval_q <= mval_d;
      pbin_q <= pbin_d;
      pval_q <= pval_d;
    end
  end
  assign o_peak_bin = pbin_q;
  assign o_peak_val = pval_q;
`else
  assign o_peak_bin = '0;
  assign o_peak_val = '0;
`endif
endmodule

// File: tb/tb_fftframe_capture.sv
// tb_fftframe_capture: frame-level reference model plus directed scenarios for fftframe_capture.
module tb_fftframe_capture;
  localparam int N = 1024;
  localparam int H = 512;
`ifdef FFTCAPTURE_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, sync = 1'b0, done = 1'b0;
  logic [31:0] res = '0;
  logic [8:0] addr = '0;
  logic [15:0] rd, dropped, pkv;
  logic [8:0] pkb;
  logic ready;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  fftframe_capture #(.LGWIDTH(10), .IWIDTH(16), .OWIDTH(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_result(res),
    .i_rd_addr(addr), .o_rd_data(rd), .i_rd_done(done), .o_frame_ready(ready),
    .o_dropped(dropped), .o_peak_bin(pkb), .o_peak_val(pkv)
  );
  task automatic check(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pw(logic [31:0] r);
    longint a = longint'($signed(r[31:16]));
    longint b = longint'($signed(r[15:0]));
    return int'((a * a + b * b) >>> 16);
  endfunction
  function automatic logic [31:0] gen(int kind, int k);
    int r, i;
    case (kind)
      0: begin r = k; i = 0; end
      1: begin r = (k == 5) ? -32768 : k * 3; i = (k == 5) ? -32768 : -k; end
      2: begin r = k * 13 - 4000; i = 1000 - k * 7; end
      3: begin r = (k == 0) ? 30000 : (k == 40 || k == 90) ? 1000 : 1; i = 0; end
      default: begin r = -k * 40; i = k * 23; end
    endcase
    return {r[15:0], i[15:0]};
  endfunction
  // reference model: whole frames, handed over three edges after their last positive bin
  int m_cur[H], m_snap[H], m_rb[H];
  bit m_started = 0, m_pend = 0, m_ready = 0, exp_ok = 0;
  int m_pos = 0, m_drop = 0, m_pkb = 0, m_pkv = 0, m_spkb = 0, m_spkv = 0, exp_rd = 0;
  longint m_cyc = 0, m_pend_t = 0;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_started = 0; m_pend = 0; m_ready = 0; m_drop = 0; m_pkb = 0; m_pkv = 0; exp_ok = 0;
    end else begin
      m_cyc++;
      exp_ok = m_ready;
      exp_rd = m_rb[addr];
      if (m_pend && m_cyc == m_pend_t) begin
        m_pend = 0;
        if (!m_ready || done) begin
          m_rb = m_snap;
          m_ready = 1;
          m_pkb = PEAK ? m_spkb : 0;
          m_pkv = PEAK ? m_spkv : 0;
        end else if (m_drop < 65535) m_drop++;
      end else if (done) m_ready = 0;
      if (ce) begin
        if (sync) begin m_started = 1; m_pos = 0; end
        else m_pos = (m_pos + 1) % N;
        if (m_started && m_pos < H) m_cur[m_pos] = pw(res);
        if (m_started && m_pos == H - 1) begin
          m_snap = m_cur;
          m_pend = 1;
          m_pend_t = m_cyc + 3;
          m_spkb = 1;
          m_spkv = m_cur[1];
          for (int k = 2; k < H; k++) if (m_cur[k] > m_spkv) begin m_spkv = m_cur[k]; m_spkb = k; end
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("ready", ready, int'(m_ready));
      check("dropped", dropped, m_drop);
      check("peak_bin", pkb, m_pkb);
      check("peak_val", pkv, m_pkv);
      if (exp_ok) check("rd_data", rd, exp_rd);
    end
  end
  task automatic send_run(int kind, int n, int start, bit sync0, int done_at);
    for (int s = 0; s < n; s++) begin
      int k = (start + s) % N;
      ce = 1'b1;
      sync = sync0 && s == 0;
      res = gen(kind, k);
      done = (s == done_at);
      addr = 9'((k * 7 + 3) % H);
      @(posedge clk); #1;
    end
    ce = 1'b0; sync = 1'b0; done = 1'b0;
  endtask
  task automatic pulse_done();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask
  task automatic rd_chk(int a, int exp, string nm);
    addr = 9'(a);
    @(posedge clk); #1;
    check(nm, rd, exp);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", ready, 0);
    check("rst_dropped", dropped, 0);
    check("rst_peak_bin", pkb, 0);
    check("rst_peak_val", pkv, 0);
    pulse_done();
    check("done_ignored", ready, 0);
    send_run(0, 512, 0, 1, -1);
    check("ramp_t0", ready, 0);
    send_run(0, 1, 512, 0, -1);
    check("ramp_t1", ready, 0);
    send_run(0, 1, 513, 0, -1);
    check("ramp_t2", ready, 0);
    send_run(0, 1, 514, 0, -1);
    check("ramp_t3", ready, 1);
    send_run(0, 509, 515, 0, -1);
    rd_chk(256, 1, "ramp_256");
    rd_chk(511, 3, "ramp_511");
    pulse_done();
    check("release", ready, 0);
    send_run(1, 1024, 0, 1, -1);
    rd_chk(5, 32768, "fullscale");
    rd_chk(0, 0, "fullscale_dc");
    pulse_done();
    send_run(2, 1024, 0, 1, -1);
    send_run(4, 1024, 0, 1, -1);
    check("drop_count", dropped, 1);
    rd_chk(5, 250, "drop_keeps_frame1");
    send_run(4, 1024, 0, 1, 100);
    check("frame3_ready", ready, 1);
    check("frame3_no_drop", dropped, 1);
    rd_chk(300, 2923, "frame3_data");
    send_run(2, 1024, 0, 1, 514);
    check("simul_ready", ready, 1);
    check("simul_no_drop", dropped, 1);
    rd_chk(5, 250, "simul_data5");
    rd_chk(300, 18, "simul_data300");
    pulse_done();
    send_run(2, 300, 0, 1, -1);
    send_run(4, 514, 0, 1, -1);
    check("resync_not_early", ready, 0);
    send_run(4, 1, 514, 0, -1);
    check("resync_ready", ready, 1);
    send_run(4, 509, 515, 0, -1);
    check("resync_no_drop", dropped, 1);
    rd_chk(100, 324, "resync_100");
    rd_chk(300, 2923, "resync_300");
    pulse_done();
    send_run(3, 1024, 0, 1, -1);
    check("peak_bin_lit", pkb, PEAK ? 40 : 0);
    check("peak_val_lit", pkv, PEAK ? 15 : 0);
    rd_chk(0, 13732, "peak_dc");
    send_run(2, 1024, 0, 1, -1);
    check("peak_drop_count", dropped, 2);
    check("peak_kept", pkb, PEAK ? 40 : 0);
    send_run(4, 200, 0, 1, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_ready", ready, 0);
    check("mrst_dropped", dropped, 0);
    check("mrst_peak", pkb, 0);
    send_run(2, 1024, 0, 0, -1);
    check("nosync_idle", ready, 0);
    send_run(4, 1024, 0, 1, -1);
    check("mrst_frame", ready, 1);
    rd_chk(300, 2923, "mrst_data");
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fftframe_capture.md
# fftframe_capture

Consumer for the pipelined FFT's output stream. It takes the bit-reversed-corrected result stream (`i_ce`/`i_sync`/`i_result`) and computes per-bin power `re²+im²` for the first N/2 bins (the positive-frequency half). It stores each frame into a ping-pong buffer and hands completed frames to the display reader through a ready/done handshake. It sits between the FFT output register and the spectrum renderer.

## Interface
Parameters:
- `LGWIDTH`, 10: log2 of FFT size N; N/2 bins are captured.
- `IWIDTH`, 16: width of each of the real and imaginary components of `i_result`.
- `OWIDTH`, 16: width of the stored power word.

Ports:
- `i_clk`, input, 1: clock. All logic is synchronous to it.
- `i_reset`, input, 1: synchronous reset, active high.
- `i_ce`, input, 1: qualifies `i_sync`/`i_result` as one FFT output sample.
- `i_sync`, input, 1: marks bin 0 of a frame; valid only with `i_ce`.
- `i_result`, input, 2*IWIDTH: real part in `[2*IWIDTH-1:IWIDTH]`, imaginary part in `[IWIDTH-1:0]`, both two's complement.
- `i_rd_addr`, input, LGWIDTH-1: bin index read from the ready bank.
- `o_rd_data`, output, OWIDTH: power of bin `i_rd_addr`, one-cycle registered read.
- `i_rd_done`, input, 1: single-cycle pulse; the reader releases the ready bank.
- `o_frame_ready`, output, 1: the read bank holds a complete, unreleased frame.
- `o_dropped`, output, 16: count of completed frames discarded because the reader had not released its bank; saturates at 0xFFFF.
- `o_peak_bin`, output, LGWIDTH-1: index of the peak bin of the last handed-over frame. See Configuration.
- `o_peak_val`, output, OWIDTH: power of the peak bin of the last handed-over frame. See Configuration.

## Operation
- **Bin counter** `bin` is LGWIDTH bits. On each `i_ce`:
  - if `i_sync`, `bin` is set to 0 for this sample and 1 afterwards;
  - otherwise `bin` increments and wraps N-1 to 0.
  - Frames are back-to-back; `i_sync` only realigns the count.
- **State machine:**
  - IDLE: ignore samples until the first `i_ce & i_sync`, then go to CAPTURE.
  - CAPTURE: write bins 0..N/2-1.
  - SKIP: discard bins N/2..N-1. A wrap to bin 0 without `i_sync` returns to CAPTURE.
  - An `i_sync` seen in CAPTURE or SKIP restarts capture at bin 0 into the same write bank. Any partial frame is discarded and is not counted as dropped.
- **Power arithmetic:**
  - `p = re*re + im*im`, 2*IWIDTH unsigned bits. This cannot overflow; the maximum is 2^(2*IWIDTH-1).
  - The stored value is `p[2*IWIDTH-1 -: OWIDTH]`, truncated with no rounding.
- **Ping-pong buffer:**
  - Two banks of N/2 × OWIDTH, with write bank `wbank` and read bank `!wbank`.
  - On completion of bin N/2-1:
    - if `o_frame_ready==0`: toggle `wbank` and set `o_frame_ready`;
    - else: keep `wbank` (the next frame overwrites it) and increment `o_dropped`.
- **Handshake:**
  - `i_rd_done` clears `o_frame_ready`.
  - `i_rd_done` while not ready is ignored.
  - If `i_rd_done` and a frame completion occur in the same cycle, the done is applied first. The new frame then swaps in, `o_frame_ready` stays 1, and no drop is counted.
- Reader contents are stable while `o_frame_ready==1`.

## Timing
- A sample accepted at edge t has its squares registered at t+1 and its RAM write at t+2. The pipeline advances every clock and is not gated by `i_ce`; a valid bit travels with the data.
- `o_frame_ready` rises, and `wbank` toggles, at edge t+3, where t is the acceptance edge of bin N/2-1.
- `o_rd_data` is valid one clock after `i_rd_addr` is presented.
- Reset values:
  - state IDLE, `bin` 0, `wbank` 0;
  - `o_frame_ready` 0, `o_dropped` 0, `o_peak_bin` 0, `o_peak_val` 0;
  - pipeline valid bits cleared;
  - RAM contents and `o_rd_data` are unspecified.
- Reset mid-capture abandons the frame. The first frame after reset requires a new `i_sync`.

## Configuration
- `FFTCAPTURE_PEAK_EN` defined:
  - a running max over bins 1..N/2-1 is kept (bin 0/DC is excluded); on ties the lower index wins;
  - `o_peak_bin`/`o_peak_val` are latched at the same edge the frame swaps in;
  - a dropped frame does not update them.
- Undefined: `o_peak_bin` and `o_peak_val` are tied to 0 and no comparator logic is built.

## Test plan
- **Ramp frame:** after reset, N=1024 samples with `i_sync` on sample 0, bin k = (re=k, im=0). Required: `o_frame_ready` rises 3 clocks after bin 511 is accepted. Reading addr 256 returns `(256²)>>16 = 1`; addr 511 returns `(511²)>>16 = 3`.
- **Full scale:** re=im=-32768 in bin 5. Required: reads `0x8000`; no overflow.
- **Drop:** send two frames without `i_rd_done`. Required: `o_dropped=1`; the read bank still holds frame 1. Then pulse `i_rd_done` during frame 3. Required: frame 3 swaps in and `o_dropped` stays 1.
- **Simultaneous:** `i_rd_done` on the exact completion cycle. Required: `o_frame_ready` stays 1, `o_dropped` is unchanged, and the new data is readable.
- **Resync:** `i_sync` at bin 300 of a capture. Required: the partial frame is discarded, the capture restarts, and the frame completes 512 samples later with no drop counted.
- **Peak** (`FFTCAPTURE_PEAK_EN`): equal maxima at bins 40 and 90, and a larger value at DC. Required: `o_peak_bin=40`.
